// File: rtl/aes_stream_wrapper.sv
// Streaming AES-256 encryptor: credit-limited pipeline around a fixed-latency core, draining into a FWFT FIFO.
// Optional build macro KEY_LATCH_EN adds i_key_load and a held 256-bit key register.
module aes_stream_wrapper #(
  parameter int NUM_FRONT  = 0,
  parameter int NUM_BACK   = 4,
  parameter int CORE_LAT   = 29,
  parameter int FIFO_DEPTH = 64
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         i_in_valid,
  output logic         o_in_ready,
  input  logic [127:0] i_state,
  input  logic [255:0] i_key,
`ifdef KEY_LATCH_EN
  input  logic         i_key_load,
`endif
  output logic         o_out_valid,
  input  logic         i_out_ready,
  output logic [127:0] o_out
);
  localparam int L  = NUM_FRONT + CORE_LAT + NUM_BACK;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0] PTR_LAST = PW'(FIFO_DEPTH - 1);

  logic          r_run;
  logic [CW-1:0] r_cnt;
  logic [L-1:0]  r_vld;
  logic          w_accept, w_pop, w_wr, w_load;
  logic [255:0]  w_key_sel, w_core_key;
  logic [127:0]  w_core_state, w_core_out, w_back_out;
  logic [127:0]  r_mem [FIFO_DEPTH];
  logic [PW-1:0] r_wr_ptr, r_rd_ptr;
  logic [CW-1:0] r_mcnt;
  logic [127:0]  r_out;
  logic          r_out_valid;

  assign o_in_ready  = r_run && (r_cnt < DEPTH_C);
  assign w_accept    = i_in_valid && o_in_ready;
  assign o_out_valid = r_out_valid;
  assign o_out       = r_out;
  assign w_pop       = r_out_valid && i_out_ready;
  assign w_wr        = r_vld[L-1];
  assign w_load      = (r_mcnt != '0) && (!r_out_valid || w_pop);

`ifdef KEY_LATCH_EN
  logic [255:0] r_key;
  always_ff @(posedge i_clk) begin
    if (i_key_load) r_key <= i_key;
  end
  // Bypass so a load coinciding with an accept encrypts that block with the new key.
  assign w_key_sel = i_key_load ? i_key : r_key;
`else
  assign w_key_sel = i_key;
`endif

  if (NUM_FRONT > 0) begin : g_front
    logic [127:0] r_fs [NUM_FRONT];
    logic [255:0] r_fk [NUM_FRONT];
    always_ff @(posedge i_clk) begin
      r_fs[0] <= i_state;
      r_fk[0] <= w_key_sel;
      for (int i = 1; i < NUM_FRONT; i++) begin
        r_fs[i] <= r_fs[i-1];
        r_fk[i] <= r_fk[i-1];
      end
    end
    assign w_core_state = r_fs[NUM_FRONT-1];
    assign w_core_key   = r_fk[NUM_FRONT-1];
  end else begin : g_no_front
    assign w_core_state = i_state;
    assign w_core_key   = w_key_sel;
  end

  aes_256 u_core (
    .i_clk   (i_clk),
    .i_state (w_core_state),
    .i_key   (w_core_key),
    .o_out   (w_core_out)
  );

  if (NUM_BACK > 0) begin : g_back
    logic [127:0] r_bk [NUM_BACK];
    always_ff @(posedge i_clk) begin
      r_bk[0] <= w_core_out;
      for (int i = 1; i < NUM_BACK; i++) r_bk[i] <= r_bk[i-1];
    end
    assign w_back_out = r_bk[NUM_BACK-1];
  end else begin : g_no_back
    assign w_back_out = w_core_out;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_run <= 1'b0;
      r_vld <= '0;
      r_cnt <= '0;
    end else begin
      r_run <= 1'b1;
      r_vld <= {r_vld[L-2:0], w_accept};
      if (w_accept && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_accept && w_pop) r_cnt <= r_cnt - CW'(1);
    end
  end

  // Storage and output data are left unreset; r_out_valid alone qualifies them.
  always_ff @(posedge i_clk) begin
    if (w_wr)   r_mem[r_wr_ptr] <= w_back_out;
    if (w_load) r_out <= r_mem[r_rd_ptr];
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_mcnt      <= '0;
      r_out_valid <= 1'b0;
    end else begin
      if (w_wr)   r_wr_ptr <= (r_wr_ptr == PTR_LAST) ? '0 : r_wr_ptr + PW'(1);
      if (w_load) r_rd_ptr <= (r_rd_ptr == PTR_LAST) ? '0 : r_rd_ptr + PW'(1);
      if (w_wr && !w_load)      r_mcnt <= r_mcnt + CW'(1);
      else if (!w_wr && w_load) r_mcnt <= r_mcnt - CW'(1);
      if (w_load)     r_out_valid <= 1'b1;
      else if (w_pop) r_out_valid <= 1'b0;
    end
  end

  a_no_overflow: assert property (@(posedge i_clk) disable iff (i_rst)
    !(w_wr && !w_load && (r_mcnt == DEPTH_C)));
endmodule

// Fully pipelined AES-256 encryption core, 29 register stages: initial key add, then two stages per round.
module aes_256 (
  input  logic         i_clk,
  input  logic [127:0] i_state,
  input  logic [255:0] i_key,
  output logic [127:0] o_out
);
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Multiplicative inverse as a^254 (maps 0 to 0), followed by the affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] a);
    logic [7:0] sq, inv;
    sq  = a;
    inv = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq  = gmul(sq, sq);
      inv = gmul(inv, sq);
    end
    return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
               ^ {inv[3:0], inv[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = sbox(s[127-8*(4*((c+r)%4)+r) -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] mix(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                           a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                           a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                           xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // Next 128-bit round key from the previous two; odd rounds produce an even word index (rot + rcon).
  function automatic logic [127:0] key_next(input logic [127:0] kp, input logic [127:0] kc,
                                            input int rnd);
    logic [31:0] t, n0, n1, n2, n3;
    t = kc[31:0];
    if (rnd % 2 == 1) t = {t[23:0], t[31:24]};
    t = {sbox(t[31:24]), sbox(t[23:16]), sbox(t[15:8]), sbox(t[7:0])};
    if (rnd % 2 == 1) t[31:24] = t[31:24] ^ 8'(8'h01 << ((rnd - 1) / 2));
    n0 = kp[127:96] ^ t;
    n1 = kp[95:64]  ^ n0;
    n2 = kp[63:32]  ^ n1;
    n3 = kp[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  logic [127:0] r_st [29];
  logic [127:0] r_kp [29];
  logic [127:0] r_kc [29];

  always_ff @(posedge i_clk) begin
    r_st[0] <= i_state ^ i_key[255:128];
    r_kp[0] <= i_key[255:128];
    r_kc[0] <= i_key[127:0];
    for (int r = 1; r <= 14; r++) begin
      r_st[2*r-1] <= sub_shift(r_st[2*r-2]);
      r_kp[2*r-1] <= r_kp[2*r-2];
      r_kc[2*r-1] <= r_kc[2*r-2];
      r_st[2*r]   <= ((r == 14) ? r_st[2*r-1] : mix(r_st[2*r-1])) ^ r_kc[2*r-1];
      r_kp[2*r]   <= r_kc[2*r-1];
      r_kc[2*r]   <= key_next(r_kp[2*r-1], r_kc[2*r-1], r);
    end
  end

  assign o_out = r_st[28];
endmodule
